a8_mc_core: RTL

//  Parametrised multicycle successor to the a7 top-level core. Loads a program over a write port, runs it
//  on an internal register file via a FETCH/DECODE/EXEC FSM and streams results out as valid-qualified

---
 rtl/a8_mc_core.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/a8_mc_core.sv
// ============================================================================
// a8_mc_core
// ----------------------------------------------------------------------------
// Multicycle program core. A program is loaded into instruction memory over
// a simple write port. It then runs on an internal register file through a
// FETCH -> DECODE -> EXEC sequence, taking 3 cycles per instruction. Results
// of OUT instructions are streamed out as valid-qualified words.
//
// Instruction word: op[15:12] rd[11:8] rs[7:4] rt/imm[3:0]
//   0 NOP   1 ADD   2 SUB   3 AND   4 OR   5 ADDI (zero-extended imm)
//   6 BEQZ  (branch if R[rs]==0, target PC+1+sext(imm))
//   7 OUT   (result = R[rs])
//   F HALT
//   8..E behave as NOP
//
// Ports
//   clk           in   1       rising-edge clock
//   reset         in   1       asynchronous reset, active low
//   start         in   1       begin execution at PC=0 (accepted in IDLE/HALT)
//   prog_we       in   1       instruction memory write enable (IDLE/HALT only)
//   prog_addr     in   IA_W    instruction memory write address
//   prog_data     in   16      instruction word to write
//   busy          out  1       core is executing (FETCH/DECODE/EXEC)
//   halted        out  1       core has executed HALT
//   pc_out        out  IA_W    current program counter
//   result        out  DATA_W  value of the most recent OUT
//   result_valid  out  1       one-cycle pulse per OUT
// ============================================================================
module a8_mc_core #(
   parameter  int DATA_W     = 32,
   parameter  int NREG       = 8,
   parameter  int IMEM_DEPTH = 16,
   localparam int IA_W       = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              prog_we,
   input  logic [IA_W-1:0]   prog_addr,
   input  logic [15:0]       prog_data,
   output logic              busy,
   output logic              halted,
   output logic [IA_W-1:0]   pc_out,
   output logic [DATA_W-1:0] result,
   output logic              result_valid
);

   localparam int         RI_W   = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [4:0] NREG_L = 5'(NREG);

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_BEQZ = 4'h6;
   localparam logic [3:0] OP_OUT  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t            state_q, state_d;

   logic [15:0]       imem [IMEM_DEPTH];
   logic [DATA_W-1:0] regs [NREG];
   logic [IA_W-1:0]   pc_q;

   logic [15:0]       ir_p0;
   logic [DATA_W-1:0] opa_p1, opb_p1;

   logic [3:0]        op, rd, rs, rt;
   logic              load_ok;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              br_taken;

   assign op = ir_p0[15:12];
   assign rd = ir_p0[11:8];
   assign rs = ir_p0[7:4];
   assign rt = ir_p0[3:0];

   // Program load and start are only accepted while the core is not running.
   assign load_ok = (state_q == S_IDLE) || (state_q == S_HALT);

   // Register indices may exceed NREG; those read as 0 and are never written.
   function automatic logic reg_ok(input logic [3:0] idx);
      return ({1'b0, idx} < NREG_L);
   endfunction

   function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
      if ((idx == 4'h0) || !reg_ok(idx))
         return '0;
      return regs[idx[RI_W-1:0]];
   endfunction

   // All arithmetic wraps modulo 2^DATA_W; no flags are kept.
   function automatic logic [DATA_W-1:0] alu(input logic [3:0]        opc,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (opc)
         OP_ADD, OP_ADDI: return a + b;
         OP_SUB:          return a - b;
         OP_AND:          return a & b;
         OP_OR:           return a | b;
         default:         return '0;
      endcase
   endfunction

   // Branch target PC+1+sext(imm). The sum is formed wider than the PC so a
   // negative offset behaves as two's complement; truncating to IA_W gives
   // the wrap modulo IMEM_DEPTH.
   function automatic logic [IA_W-1:0] br_target(input logic [IA_W-1:0] pc,
                                                 input logic [3:0]      imm);
      logic signed [IA_W+3:0] off;
      logic signed [IA_W+3:0] base;
      logic signed [IA_W+3:0] sum;
      off  = {{IA_W{imm[3]}}, imm};
      base = {4'b0000, pc};
      sum  = base + off + (IA_W+4)'(1);
      return sum[IA_W-1:0];
   endfunction

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      halted  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            busy    = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            busy    = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            busy    = 1'b1;
            state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (start)
               state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Instruction memory is not reset; a loaded program survives reset. A
   // write accepted together with start lands at this edge, before the
   // following FETCH reads it.
   always_ff @(posedge clk) begin
      if (prog_we && load_ok)
         imem[prog_addr] <= prog_data;
   end

   // ---------------------------------------------------------------------
   // Stage p0: FETCH -- instruction register
   // Stage p1: DECODE -- operand read (ADDI substitutes the zero-extended
   //           immediate for the rt operand)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (state_q == S_FETCH)
         ir_p0 <= imem[pc_q];
      if (state_q == S_DECODE) begin
         opa_p1 <= rd_reg(rs);
         opb_p1 <= (op == OP_ADDI) ? DATA_W'(rt) : rd_reg(rt);
      end
   end

   // ---------------------------------------------------------------------
   // Stage p2: EXEC -- writeback, PC update, result output
   // ---------------------------------------------------------------------
   always_comb begin
      wr_en    = 1'b0;
      wr_data  = alu(op, opa_p1, opb_p1);
      br_taken = (op == OP_BEQZ) && (opa_p1 == '0);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:
            wr_en = (rd != 4'h0) && reg_ok(rd);
         default: wr_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         result_valid <= 1'b0;
         if (load_ok && start)
            pc_q <= '0;
         if (state_q == S_EXEC) begin
            pc_q <= br_taken ? br_target(pc_q, rt) : pc_q + IA_W'(1);
            if (wr_en)
               regs[rd[RI_W-1:0]] <= wr_data;
            if (op == OP_OUT) begin
               result       <= opa_p1;
               result_valid <= 1'b1;
            end
         end
      end
   end

   assign pc_out = pc_q;

endmodule
